// File: rtl/rvv_vd_collector_pkg.sv
// Shared types for the vector destination collector: element-width codes, operand kinds,
// collector FSM states and lane bus geometry.
package rvv_vd_collector_pkg;

  typedef enum logic [2:0] {
    Vsew8  = 3'd0,
    Vsew16 = 3'd1,
    Vsew32 = 3'd2,
    Vsew64 = 3'd3
  } vsew_e;

  typedef enum logic [1:0] {
    OpVV = 2'd0,
    OpVX = 2'd1,
    OpVI = 2'd2
  } op_type_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StWb      = 2'd2
  } coll_state_e;

  // Each lane drives a 64-bit result slot and a 17-bit chunk index.
  localparam int unsigned LaneBusW = 64;
  localparam int unsigned RegiW    = 17;
  localparam int unsigned VlW      = 17;

  function automatic int unsigned sew_bits(input logic [2:0] vsew);
    return 32'd8 << vsew;
  endfunction

endpackage

// File: rtl/rvv_vd_collector_if.sv
// Lane-array result bus plus the VRF write port seen by the collector.
interface rvv_vd_collector_if
  import rvv_vd_collector_pkg::*;
#(
  parameter int unsigned VLEN     = 128,
  parameter int unsigned NB_LANES = 1
) ();

  localparam int unsigned NL = 1 << NB_LANES;

  logic [LaneBusW*NL-1:0] lane_vd;
  logic [RegiW*NL-1:0]    lane_regi;
  logic [NL-1:0]          lane_valid;
  logic                   alu_done;

  logic                   wb_valid;
  logic                   wb_ready;
  logic [4:0]             wb_vd_index;
  logic [VLEN-1:0]        wb_data;

  modport master (
    output lane_vd, lane_regi, lane_valid, alu_done, wb_ready,
    input  wb_valid, wb_vd_index, wb_data
  );

  modport slave (
    input  lane_vd, lane_regi, lane_valid, alu_done, wb_ready,
    output wb_valid, wb_vd_index, wb_data
  );

endinterface

// File: rtl/rvv_vd_collector_chunk_merge.sv
// Decides whether one lane chunk lands in the destination buffer, and which bits of it.
module rvv_vd_collector_chunk_merge
  import rvv_vd_collector_pkg::*;
#(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned LANE_WIDTH = 3,
  parameter bit          IsLane0    = 1'b0,
  localparam int unsigned LW        = 1 << LANE_WIDTH,
  localparam int unsigned NCH       = VLEN / LW,
  localparam int unsigned ChIdxW    = $clog2(NCH)
) (
  input  logic              lane_valid_i,
  input  logic [LW-1:0]     lane_data_i,
  input  logic [RegiW-1:0]  lane_regi_i,
  input  logic [2:0]        vsew_i,
  input  logic [VlW-1:0]    vl_i,
  input  logic              mask_en_i,
  input  logic [VLEN-1:0]   v0_i,
  input  logic              scalar_i,
  output logic              we_o,
  output logic [ChIdxW-1:0] chunk_o,
  output logic [LW-1:0]     bit_mask_o,
  output logic [LW-1:0]     data_o
);

  localparam int unsigned VIdxW = $clog2(VLEN);

  logic [31:0] sew;
  logic [31:0] bit_off;
  logic [31:0] elem;
  logic        in_range;
  logic        active;

  always_comb begin
    sew      = sew_bits(vsew_i);
    bit_off  = 32'(lane_regi_i) << LANE_WIDTH;
    elem     = bit_off >> ({29'd0, vsew_i} + 32'd3);
    in_range = 32'(lane_regi_i) < NCH;
    // Reductions bypass vl/mask: only lane 0 may touch element 0.
    if (scalar_i) begin
      active = IsLane0 && (bit_off < sew);
    end else begin
      active = (elem < 32'(vl_i)) && (!mask_en_i || v0_i[elem[VIdxW-1:0]]);
    end
    we_o = lane_valid_i && in_range && active;
    // Narrow elements occupy only the low SEW bits of the chunk.
    for (int unsigned b = 0; b < LW; b++) begin
      bit_mask_o[b] = (b < sew);
    end
    chunk_o = lane_regi_i[ChIdxW-1:0];
    data_o  = lane_data_i;
  end

endmodule

// File: rtl/rvv_vd_collector.sv
// Collects lane result chunks into a full vd register and writes it back to the VRF.
module rvv_vd_collector
  import rvv_vd_collector_pkg::*;
#(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned LANE_WIDTH = 3,
  parameter int unsigned NB_LANES   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       vsew,
  input  logic [VlW-1:0]   vl,
  input  logic [4:0]       vd_index,
  input  logic             mask_en,
  input  logic [VLEN-1:0]  vd_old,
  input  logic [VLEN-1:0]  v0,
  input  logic             scalar_res,
  output logic             busy,
  rvv_vd_collector_if.slave bus
);

  localparam int unsigned NL     = 1 << NB_LANES;
  localparam int unsigned LW     = 1 << LANE_WIDTH;
  localparam int unsigned NCH    = VLEN / LW;
  localparam int unsigned ChIdxW = $clog2(NCH);

  coll_state_e     state_q, state_d;
  logic            busy_q, busy_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      vd_idx_q, vd_idx_d;
  logic [2:0]      vsew_q, vsew_d;
  logic [VlW-1:0]  vl_q, vl_d;
  logic            mask_q, mask_d;
  logic [VLEN-1:0] v0_q, v0_d;
  logic [VLEN-1:0] buf_q, buf_d;

  logic              lane_we   [NL];
  logic [ChIdxW-1:0] lane_ch   [NL];
  logic [LW-1:0]     lane_mask [NL];
  logic [LW-1:0]     lane_data [NL];

  for (genvar i = 0; i < NL; i++) begin : g_lane
    rvv_vd_collector_chunk_merge #(
      .VLEN       (VLEN),
      .LANE_WIDTH (LANE_WIDTH),
      .IsLane0    (i == 0)
    ) u_merge (
      .lane_valid_i (bus.lane_valid[i]),
      .lane_data_i  (bus.lane_vd[LaneBusW*i +: LW]),
      .lane_regi_i  (bus.lane_regi[RegiW*i +: RegiW]),
      .vsew_i       (vsew_q),
      .vl_i         (vl_q),
      .mask_en_i    (mask_q),
      .v0_i         (v0_q),
      .scalar_i     (scalar_res),
      .we_o         (lane_we[i]),
      .chunk_o      (lane_ch[i]),
      .bit_mask_o   (lane_mask[i]),
      .data_o       (lane_data[i])
    );
  end

  // Upper bits of each 64-bit lane slot are not part of the chunk.
  logic unused_lane_vd;
  assign unused_lane_vd = ^bus.lane_vd;

  always_comb begin
    state_d  = state_q;
    vd_idx_d = vd_idx_q;
    vsew_d   = vsew_q;
    vl_d     = vl_q;
    mask_d   = mask_q;
    v0_d     = v0_q;
    buf_d    = buf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StCollect;
          buf_d    = vd_old;
          vd_idx_d = vd_index;
          vsew_d   = vsew;
          vl_d     = vl;
          mask_d   = mask_en;
          v0_d     = v0;
        end
      end
      StCollect: begin
        // Ascending lane order so the higher lane wins on a shared chunk.
        for (int unsigned k = 0; k < NCH; k++) begin
          for (int unsigned i = 0; i < NL; i++) begin
            if (lane_we[i] && (lane_ch[i] == ChIdxW'(k))) begin
              buf_d[k*LW +: LW] = (buf_d[k*LW +: LW] & ~lane_mask[i]) |
                                  (lane_data[i] & lane_mask[i]);
            end
          end
        end
        if (bus.alu_done) begin
          state_d = StWb;
        end
      end
      StWb: begin
        if (wb_valid_q && bus.wb_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d     = (state_d != StIdle);
    wb_valid_d = (state_d == StWb);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      vd_idx_q   <= '0;
      vsew_q     <= '0;
      vl_q       <= '0;
      mask_q     <= 1'b0;
      v0_q       <= '0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      wb_valid_q <= wb_valid_d;
      vd_idx_q   <= vd_idx_d;
      vsew_q     <= vsew_d;
      vl_q       <= vl_d;
      mask_q     <= mask_d;
      v0_q       <= v0_d;
      buf_q      <= buf_d;
    end
  end

  assign busy            = busy_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_vd_index = vd_idx_q;
  assign bus.wb_data     = buf_q;

endmodule

// File: tb/tb_rvv_vd_collector.sv
// Directed bench for rvv_vd_collector with an element-level reference model.
module tb_rvv_vd_collector;
  import rvv_vd_collector_pkg::*;

  localparam int unsigned VLEN       = 128;
  localparam int unsigned LANE_WIDTH = 3;
  localparam int unsigned NB_LANES   = 1;
  localparam int unsigned NL         = 2;
  localparam int unsigned LW         = 8;
  localparam int unsigned NCH        = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [2:0]      vsew;
  logic [16:0]     vl;
  logic [4:0]      vd_index;
  logic            mask_en;
  logic [VLEN-1:0] vd_old;
  logic [VLEN-1:0] v0;
  logic            scalar_res;
  logic            busy;

  rvv_vd_collector_if #(.VLEN(VLEN), .NB_LANES(NB_LANES)) bus ();

  rvv_vd_collector #(
    .VLEN       (VLEN),
    .LANE_WIDTH (LANE_WIDTH),
    .NB_LANES   (NB_LANES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .vsew       (vsew),
    .vl         (vl),
    .vd_index   (vd_index),
    .mask_en    (mask_en),
    .vd_old     (vd_old),
    .v0         (v0),
    .scalar_res (scalar_res),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: phase 0 idle, 1 collecting, 2 waiting for the VRF.
  int              m_phase = 0;
  logic [VLEN-1:0] m_buf = '0;
  logic [4:0]      m_idx = '0;
  logic [2:0]      m_vsew = '0;
  logic [16:0]     m_vl = '0;
  logic            m_mask = 1'b0;
  logic [VLEN-1:0] m_v0 = '0;

  task automatic check(input string name, input logic [VLEN-1:0] act,
                       input logic [VLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic model_beat();
    for (int i = 0; i < NL; i++) begin
      int unsigned   c;
      int unsigned   sew;
      int unsigned   e;
      logic [LW-1:0] d;
      bit            ok;
      c   = bus.lane_regi[17*i +: 17];
      sew = 8 << m_vsew;
      e   = c * LW / sew;
      d   = bus.lane_vd[64*i +: LW];
      if (!bus.lane_valid[i] || c >= NCH) ok = 1'b0;
      else if (scalar_res)                ok = (i == 0) && (e == 0);
      else                                ok = (e < m_vl) && (!m_mask || m_v0[e]);
      if (ok) begin
        for (int b = 0; b < LW && b < sew; b++) m_buf[c*LW + b] = d[b];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_phase = 0;
      m_buf   = '0;
      m_idx   = '0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          m_buf   = vd_old;
          m_idx   = vd_index;
          m_vsew  = vsew;
          m_vl    = vl;
          m_mask  = mask_en;
          m_v0    = v0;
        end
        1: begin
          model_beat();
          if (bus.alu_done) m_phase = 2;
        end
        default: if (bus.wb_ready) m_phase = 0;
      endcase
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", VLEN'(busy), VLEN'(m_phase != 0));
      check("wb_valid", VLEN'(bus.wb_valid), VLEN'(m_phase == 2));
      if (m_phase == 2) begin
        check("wb_data", bus.wb_data, m_buf);
        check("wb_vd_index", VLEN'(bus.wb_vd_index), VLEN'(m_idx));
      end
    end
  end

  task automatic begin_instr(input logic [2:0] s, input logic [16:0] l, input logic [4:0] idx,
                             input logic msk, input logic [VLEN-1:0] old,
                             input logic [VLEN-1:0] m0);
    vsew = s; vl = l; vd_index = idx; mask_en = msk; vd_old = old; v0 = m0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input bit lv0, input int r0, input logic [7:0] d0,
                      input bit lv1, input int r1, input logic [7:0] d1, input bit done);
    bus.lane_valid = {lv1, lv0};
    bus.lane_regi  = {17'(r1), 17'(r0)};
    bus.lane_vd    = {56'h0, d1, 56'h0, d0};
    bus.alu_done   = done;
    tick();
    bus.lane_valid = '0;
    bus.alu_done   = 1'b0;
  endtask

  // Called right after the alu_done beat; checks the write request against a literal.
  task automatic expect_wb(input string name, input logic [VLEN-1:0] lit, input logic [4:0] idx);
    check({name, "_valid"}, VLEN'(bus.wb_valid), VLEN'(1));
    check({name, "_data"}, bus.wb_data, lit);
    check({name, "_idx"}, VLEN'(bus.wb_vd_index), VLEN'(idx));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; vsew = '0; vl = '0; vd_index = '0; mask_en = 1'b0;
    vd_old = '0; v0 = '0; scalar_res = 1'b0;
    bus.lane_vd = '0; bus.lane_regi = '0; bus.lane_valid = '0; bus.alu_done = 1'b0;
    bus.wb_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", VLEN'(busy), '0);
    check("rst_wb_valid", VLEN'(bus.wb_valid), '0);
    check("rst_wb_data", bus.wb_data, '0);
    check("rst_wb_idx", VLEN'(bus.wb_vd_index), '0);
    tick();

    // 1: full unmasked byte fill, two lanes per beat.
    begin_instr(3'd0, 17'd16, 5'd5, 1'b0, '0, '0);
    for (int k = 0; k < 8; k++) begin
      beat(1'b1, 2*k, 8'(8'hA0 + 2*k), 1'b1, 2*k + 1, 8'(8'hA1 + 2*k), k == 7);
    end
    expect_wb("t1", 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0, 5'd5);
    tick(); tick();

    // 2: tail undisturbed beyond vl=5.
    begin_instr(3'd0, 17'd5, 5'd7, 1'b0, {VLEN{1'b1}}, '0);
    for (int k = 0; k < 8; k++) beat(1'b1, 2*k, 8'h00, 1'b1, 2*k + 1, 8'h00, k == 7);
    expect_wb("t2", 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FF00_0000_0000, 5'd7);
    tick(); tick();

    // 3: masked 32-bit elements, v0 = 0b0101.
    begin_instr(3'd2, 17'd4, 5'd12, 1'b1, {16{8'hCC}}, 128'h5);
    for (int k = 0; k < 8; k++) beat(1'b1, 2*k, 8'h11, 1'b1, 2*k + 1, 8'h11, k == 7);
    expect_wb("t3", 128'hCCCCCCCC_11111111_CCCCCCCC_11111111, 5'd12);
    tick(); tick();

    // 4: scalar result; lane 1 and lane 0 beyond element 0 are ignored.
    scalar_res = 1'b1;
    begin_instr(3'd2, 17'd4, 5'd3, 1'b0, {4{32'hDEADBEEF}}, '0);
    beat(1'b1, 0, 8'h78, 1'b1, 4, 8'h99, 1'b0);
    beat(1'b1, 1, 8'h56, 1'b1, 5, 8'h99, 1'b0);
    beat(1'b1, 2, 8'h34, 1'b1, 0, 8'h99, 1'b0);
    beat(1'b1, 3, 8'h12, 1'b1, 7, 8'h99, 1'b0);
    beat(1'b1, 4, 8'h55, 1'b0, 0, 8'h00, 1'b1);
    expect_wb("t4", 128'hDEADBEEF_DEADBEEF_DEADBEEF_12345678, 5'd3);
    scalar_res = 1'b0;
    tick(); tick();

    // 5: back-pressure, lane priority, out-of-range chunk, ignored start.
    bus.wb_ready = 1'b0;
    begin_instr(3'd0, 17'd16, 5'd21, 1'b0, '0, '0);
    beat(1'b1, 3, 8'h11, 1'b1, 3, 8'h22, 1'b0);
    beat(1'b1, 16, 8'h77, 1'b1, 0, 8'h5A, 1'b1);
    expect_wb("t5", 128'h0000_0000_0000_0000_0000_0000_2200_005A, 5'd21);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        vd_old = {VLEN{1'b1}}; vd_index = 5'd30; start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    expect_wb("t5_hold", 128'h0000_0000_0000_0000_0000_0000_2200_005A, 5'd21);
    bus.wb_ready = 1'b1;
    tick(); tick();
    check("t5_idle_busy", VLEN'(busy), '0);

    // 6: reset mid-collect, then a clean instruction.
    begin_instr(3'd0, 17'd16, 5'd9, 1'b0, {16{8'h33}}, '0);
    beat(1'b1, 0, 8'hEE, 1'b0, 0, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_busy", VLEN'(busy), '0);
    check("t6_wb_valid", VLEN'(bus.wb_valid), '0);
    check("t6_wb_data", bus.wb_data, '0);
    tick();
    begin_instr(3'd0, 17'd16, 5'd4, 1'b0, '0, '0);
    beat(1'b1, 0, 8'h42, 1'b0, 0, 8'h00, 1'b1);
    expect_wb("t6", 128'h42, 5'd4);
    tick(); tick();

    // 7: vl = 0 leaves vd_old intact.
    begin_instr(3'd0, 17'd0, 5'd1, 1'b0, {8{16'hBEEF}}, '0);
    beat(1'b1, 0, 8'h01, 1'b1, 1, 8'h02, 1'b0);
    beat(1'b1, 2, 8'h03, 1'b1, 3, 8'h04, 1'b1);
    expect_wb("t7", {8{16'hBEEF}}, 5'd1);
    tick(); tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
